// File: rtl/ccg_code_pkg.sv
// Shared types, widths and the golden forward map of the 4-in / 13-out CCG benchmark.
// CODE_TABLE is regenerated by the benchmark flow; every entry satisfies f9 = ~f1.
package ccg_code_pkg;

  localparam int CW    = 13;
  localparam int IW    = 4;
  localparam int DEPTH = 1 << IW;

  typedef logic [CW-1:0] code_t;
  typedef logic [IW-1:0] idx_t;
  typedef logic [IW:0]   cnt_t;

  localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

  localparam code_t CODE_TABLE [DEPTH] = '{
    13'h1FA4, 13'h0A51, 13'h1FA4, 13'h0C33,
    13'h1366, 13'h06E9, 13'h1B1C, 13'h0C8F,
    13'h1572, 13'h0C33, 13'h1FA4, 13'h13D8,
    13'h0A45, 13'h1796, 13'h04BB, 13'h11F0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ccg_code_rom.sv
// Combinational index -> codeword lookup; swap CODE_TABLE to retarget another benchmark.
module ccg_code_rom
  import ccg_code_pkg::*;
(
  input  idx_t  idx_i,
  output code_t code_o
);

  assign code_o = CODE_TABLE[idx_i];

endmodule

// File: rtl/ccg_code_inverter.sv
// Sequential inverse of the CCG forward map: scans all table entries for a latched
// codeword and reports lowest matching index, hit, multiplicity and match count.
module ccg_code_inverter
  import ccg_code_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic          out_hit,
  output logic          out_multi,
  output logic [IW:0]   out_count
);

  state_e state_q, state_d;
  cnt_t   idx_q, idx_d;
  code_t  code_q, code_d;
  code_t  cand_q, cand_d;
  idx_t   cand_idx_q, cand_idx_d;
  logic   cand_vld_q, cand_vld_d;
  idx_t   index_q, index_d;
  logic   hit_q, hit_d;
  logic   multi_q, multi_d;
  cnt_t   count_q, count_d;
  code_t  rom_code_s;
  logic   match_s;

  ccg_code_rom u_rom (
    .idx_i  (idx_q[IW-1:0]),
    .code_o (rom_code_s)
  );

  // The ROM read is registered into cand_q and compared one cycle later, so each
  // candidate costs one fetch cycle plus one compare cycle in the pipeline.
  assign match_s = cand_vld_q && (cand_q == code_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    code_d     = code_q;
    cand_d     = cand_q;
    cand_idx_d = cand_idx_q;
    cand_vld_d = cand_vld_q;
    index_d    = index_q;
    hit_d      = hit_q;
    multi_d    = multi_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d     = in_code;
          idx_d      = '0;
          cand_vld_d = 1'b0;
          index_d    = '0;
          hit_d      = 1'b0;
          multi_d    = 1'b0;
          count_d    = '0;
          state_d    = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        cand_d     = rom_code_s;
        cand_idx_d = idx_q[IW-1:0];
        // idx_q[IW] marks "all entries fetched"; no wrap back to entry 0.
        cand_vld_d = ~idx_q[IW];
        if (!idx_q[IW]) begin
          idx_d = idx_q + cnt_t'(1);
        end else begin
          idx_d = idx_q;
        end
        if (match_s) begin
          count_d = count_q + cnt_t'(1);
          if (!hit_q) begin
            hit_d   = 1'b1;
            index_d = cand_idx_q;
          end else begin
            multi_d = 1'b1;
          end
        end else begin
          count_d = count_q;
        end
        if (cand_vld_q && ((cand_idx_q == LAST_IDX) || (EARLY_EXIT && match_s))) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scan pipeline and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      code_q     <= '0;
      cand_q     <= '0;
      cand_idx_q <= '0;
      cand_vld_q <= 1'b0;
      index_q    <= '0;
      hit_q      <= 1'b0;
      multi_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      cand_q     <= cand_d;
      cand_idx_q <= cand_idx_d;
      cand_vld_q <= cand_vld_d;
      index_q    <= index_d;
      hit_q      <= hit_d;
      multi_q    <= multi_d;
      count_q    <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_index = index_q;
  assign out_hit   = hit_q;
  assign out_multi = multi_q;
  assign out_count = count_q;

endmodule
